// File: rtl/aes_dec_round_sequencer.sv
// Iterative AES-128 decryption controller: whitening on accept, then NR passes through one
// shared external inverse-round datapath, the last pass without InvMixColumns.
module aes_dec_round_sequencer #(
    parameter int NR     = 10,
    parameter int DP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_data,
    output logic [127:0] dp_in,
    output logic [127:0] dp_key,
    output logic         dp_last,
    output logic         dp_issue,
    input  logic [127:0] dp_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int WCW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

    state_t         state;
    logic [3:0]     round;
    logic [WCW-1:0] wait_cnt;
    logic [127:0]   wreg;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid/out_data hold until out_ready, and ready never waits on valid.
    always_comb begin
        key_idx = 4'd0;
        case (state)
            IDLE:      key_idx = 4'(NR);
            RUN, WAIT: key_idx = round;
            default:   key_idx = 4'd0;
        endcase
    end

    // wreg holds the whitened block for the first issue and each captured round result
    // afterwards, so the datapath need not hold dp_out beyond its valid cycle.
    assign dp_in   = wreg;
    assign dp_key  = key_data;
    assign dp_last = (state == RUN) && (round == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            dp_issue  <= 1'b0;
            busy      <= 1'b0;
            round     <= 4'd0;
            wait_cnt  <= '0;
            wreg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wreg     <= in_data ^ key_data;
                        round    <= 4'(NR - 1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        dp_issue <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    dp_issue <= 1'b0;
                    wait_cnt <= WCW'(DP_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end else if (round == 4'd0) begin
                        out_data  <= dp_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wreg     <= dp_out;
                        round    <= round - 4'd1;
                        dp_issue <= 1'b1;
                        state    <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_round_sequencer.sv
// Bench for aes_dec_round_sequencer: behavioural AES inverse-cipher model drives the datapath
// and predicts plaintext; two builds (DP_LAT=1 and DP_LAT=3).
module tb_aes_dec_round_sequencer;

    localparam int NR = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         in_valid, in_ready, out_valid, out_ready, dp_last, dp_issue, busy;
    logic [127:0] in_data, key_data, dp_in, dp_key, dp_out, out_data;
    logic [3:0]   key_idx;

    logic         in_valid_3, in_ready_3, out_valid_3, out_ready_3, dp_last_3, dp_issue_3, busy_3;
    logic [127:0] in_data_3, key_data_3, dp_in_3, dp_key_3, dp_out_3, out_data_3;
    logic [3:0]   key_idx_3;

    logic [127:0] rk [0:NR];
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];

    assign key_data   = (key_idx <= NR) ? rk[key_idx] : '0;
    assign key_data_3 = (key_idx_3 <= NR) ? rk[key_idx_3] : '0;

    aes_dec_round_sequencer #(.NR(NR), .DP_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_idx(key_idx), .key_data(key_data), .dp_in(dp_in), .dp_key(dp_key),
        .dp_last(dp_last), .dp_issue(dp_issue), .dp_out(dp_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_dec_round_sequencer #(.NR(NR), .DP_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid_3), .in_ready(in_ready_3), .in_data(in_data_3),
        .key_idx(key_idx_3), .key_data(key_data_3), .dp_in(dp_in_3), .dp_key(dp_key_3),
        .dp_last(dp_last_3), .dp_issue(dp_issue_3), .dp_out(dp_out_3), .out_valid(out_valid_3),
        .out_ready(out_ready_3), .out_data(out_data_3), .busy(busy_3)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One FIPS-197 inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input bit last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   o [16];
        logic [7:0]   c [4];
        logic [127:0] res;
        c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                t[row+4*col] = isbox[b[row + 4*((col - row + 4) % 4)]] ^ k[127-8*(row+4*col) -: 8];
        for (int col = 0; col < 4; col++)
            for (int i = 0; i < 4; i++) begin
                o[i+4*col] = 8'h00;
                for (int j = 0; j < 4; j++) o[i+4*col] = o[i+4*col] ^ gmul(c[(j-i+4)%4], t[j+4*col]);
                if (last) o[i+4*col] = t[i+4*col];
            end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
        return res;
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [127:0] s = ct ^ rk[NR];
        for (int r = NR - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
        return s;
    endfunction

    task automatic build_sbox();
        logic [7:0] p, a;
        for (int n = 0; n < 256; n++) begin
            a = n[7:0];
            p = 8'h01;
            for (int e = 0; e < 254; e++) p = gmul(p, a);
            if (n == 0) p = 8'h00;
            sbox[n] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
        end
        for (int n = 0; n < 256; n++) isbox[sbox[n]] = n[7:0];
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Datapath models: result appears exactly DP_LAT cycles after the issue, noise otherwise.
    logic [127:0] p3 [3];
    always @(posedge clk) begin
        dp_out <= dp_issue ? inv_round(dp_in, dp_key, dp_last) : rnd128();
        p3[0]  <= dp_issue_3 ? inv_round(dp_in_3, dp_key_3, dp_last_3) : rnd128();
        p3[1]  <= p3[0];
        p3[2]  <= p3[1];
    end
    assign dp_out_3 = p3[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int idx_q[$];
    bit last_q[$];
    always @(negedge clk) begin
        if (!rst && dp_issue) begin
            idx_q.push_back(int'(key_idx));
            last_q.push_back(dp_last);
        end
    end

    logic [127:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input bit hold, output int t);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        t = cyc;
        @(negedge clk);
        if (!hold) begin
            in_valid = 1'b0;
            in_data  = rnd128();
        end
    endtask

    task automatic wait_out(input bit rand_ready, output int t);
        int n = 0;
        while (!out_valid && n < 200) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        check("out_valid_wait", out_valid, 1);
        t = cyc;
    endtask

    task automatic take(input string tag);
        logic [127:0] e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check(tag, out_data, e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop"}, out_valid, 0);
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, th, n;
        logic [127:0] a, b;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid_3 = 1'b0; in_data_3 = '0; out_ready_3 = 1'b0;
        build_sbox();
        expand_key(FIPS_KEY);
        repeat (3) @(negedge clk);

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_dp_issue", dp_issue, 0);
        check("rst_busy", busy, 0);
        check("rst_key_idx", key_idx, NR);
        check("rst_in_ready_3", in_ready_3, 1);
        rst = 1'b0;
        @(negedge clk);

        // DP_LAT=3 build, known-answer vector
        in_valid_3 = 1'b1;
        in_data_3  = FIPS_CT;
        t = cyc;
        @(negedge clk);
        in_valid_3 = 1'b0;
        n = 0;
        while (!out_valid_3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("lat3_latency", cyc - t, 41);
        check("lat3_data", out_data_3, FIPS_PT);
        out_ready_3 = 1'b1;
        @(negedge clk);
        out_ready_3 = 1'b0;
        check("lat3_drop", out_valid_3, 0);

        // Known-answer vector, latency and issue sequence
        idx_q.delete();
        last_q.delete();
        check("idle_key_idx", key_idx, NR);
        exp_q.push_back(FIPS_PT);
        send(FIPS_CT, 0, t);
        wait_out(0, t2);
        check("kat_latency", t2 - t, 21);
        take("kat_data");
        check("kat_issue_count", idx_q.size(), NR);
        for (int i = 0; i < idx_q.size(); i++) begin
            check($sformatf("kat_key_idx%0d", i), idx_q[i], NR - 1 - i);
            check($sformatf("kat_last%0d", i), last_q[i], (i == NR - 1));
        end
        check("kat_in_ready_after", in_ready, 1);

        // Backpressure with in_valid noise
        a = rnd128();
        exp_q.push_back(ref_decrypt(a));
        send(a, 0, t);
        wait_out(0, t2);
        for (int i = 0; i < 7; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, exp_q[0]);
            check("bp_in_ready", in_ready, 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rnd128();
            @(negedge clk);
        end
        in_valid = 1'b0;
        take("bp_data");
        check("bp_in_ready_after", in_ready, 1);
        check("bp_busy_after", busy, 0);
        @(negedge clk);
        check("bp_no_ghost_accept", busy, 0);

        // Back-to-back with in_valid held high
        a = rnd128();
        b = rnd128();
        exp_q.push_back(ref_decrypt(a));
        exp_q.push_back(ref_decrypt(b));
        send(a, 1, t);
        in_data = b;
        wait_out(0, th);
        take("b2b_first");
        check("b2b_in_ready", in_ready, 1);
        t2 = cyc;
        check("b2b_accept_cycle", t2, th + 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_busy", busy, 1);
        wait_out(0, t);
        check("b2b_latency", t - t2, 21);
        take("b2b_second");

        // Reset in the middle of a block
        idx_q.delete();
        last_q.delete();
        exp_q.push_back(ref_decrypt(rnd128()));
        send(exp_q[0], 0, t);
        n = 0;
        while (!(dp_issue && key_idx == 4'd5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_round5", (dp_issue && key_idx == 4'd5), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_dp_issue", dp_issue, 0);
        check("mid_rst_out_data", out_data, 0);
        exp_q.push_back(FIPS_PT);
        send(FIPS_CT, 0, t);
        wait_out(0, t2);
        check("after_rst_latency", t2 - t, 21);
        take("after_rst_data");

        // Random key schedules, ciphertexts and sink behaviour
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                for (int r = 0; r <= NR; r++) rk[r] = rnd128();
            a = rnd128();
            exp_q.push_back(ref_decrypt(a));
            send(a, 0, t);
            wait_out(1, t2);
            check($sformatf("rand%0d_latency", k), t2 - t, 21);
            repeat ($urandom_range(0, 3)) begin
                check($sformatf("rand%0d_hold", k), out_data, exp_q[0]);
                @(negedge clk);
            end
            take($sformatf("rand%0d_data", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
